cache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate cache with its own controller FSM. Sits between the CPU request port (read/write/Address/Write_Data, answered by rData/hit) and a word-wide main-memory port. The block sequences tag lookup, dirty-line write-back and line refill, then completes the CPU request with a single-cycle `hit` pulse.

---
 rtl/cache_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_cache_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-back, write-allocate cache with its controller FSM.
// Define CACHE_STATS_EN to add saturating hit_cnt/miss_cnt/wb_cnt outputs.
module cache_ctrl #(
    parameter int MEM_ADDR_SIZE = 8,
    parameter int WORD_SIZE_BIT = 32,
    parameter int ADDR_W        = MEM_ADDR_SIZE,
    parameter int DATA_W        = WORD_SIZE_BIT,
    parameter int INDEX_W       = 2,
    parameter int WOFF_W        = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Write_Data,
    output logic [DATA_W-1:0] rData,
    output logic              hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt,
    output logic [15:0]       wb_cnt
`endif
);
    localparam int TAG_W = ADDR_W - INDEX_W - WOFF_W - 2;
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << WOFF_W;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_COMPARE   = 2'd1;
    localparam logic [1:0] S_WRITEBACK = 2'd2;
    localparam logic [1:0] S_REFILL    = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wr;
    logic              r_refilled;
    logic [WOFF_W-1:0] r_cnt;
    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES][WORDS];

    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_idx;
    logic [WOFF_W-1:0]  w_woff;
    logic               w_match;
    logic               w_xfer;
    logic               w_last;

    assign w_tag   = r_addr[ADDR_W-1 -: TAG_W];
    assign w_idx   = r_addr[2+WOFF_W +: INDEX_W];
    assign w_woff  = r_addr[2 +: WOFF_W];
    assign w_match = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_xfer  = mem_req && mem_ready;
    assign w_last  = (r_cnt == WOFF_W'(WORDS - 1));

    // Outputs decode from state only, so reset silences them immediately.
    always_comb begin
        hit       = 1'b0;
        rData     = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            S_COMPARE: begin
                hit = w_match;
                if (w_match && !r_wr)
                    rData = r_data[w_idx][w_woff];
            end
            S_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_tag[w_idx], w_idx, r_cnt, 2'b00};
                mem_wdata = r_data[w_idx][r_cnt];
            end
            S_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {w_tag, w_idx, r_cnt, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wr       <= 1'b0;
            r_refilled <= 1'b0;
            r_cnt      <= '0;
            r_valid    <= '0;
            r_dirty    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (read || write) begin
                        r_addr     <= Address;
                        r_wdata    <= Write_Data;
                        r_wr       <= write;
                        r_refilled <= 1'b0;
                        r_state    <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (w_match) begin
                        if (r_wr)
                            r_dirty[w_idx] <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= '0;
                        if (r_valid[w_idx] && r_dirty[w_idx])
                            r_state <= S_WRITEBACK;
                        else
                            r_state <= S_REFILL;
                    end
                end
                S_WRITEBACK: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt + WOFF_W'(1);
                        if (w_last) begin
                            r_dirty[w_idx] <= 1'b0;
                            r_state        <= S_REFILL;
                        end
                    end
                end
                default: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt + WOFF_W'(1);
                        // Line stays invalid until every word has landed.
                        if (w_last) begin
                            r_valid[w_idx] <= 1'b1;
                            r_dirty[w_idx] <= 1'b0;
                            r_refilled     <= 1'b1;
                            r_state        <= S_COMPARE;
                        end else begin
                            r_valid[w_idx] <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (r_state == S_COMPARE && w_match && r_wr)
            r_data[w_idx][w_woff] <= r_wdata;
        if (r_state == S_REFILL && w_xfer) begin
            r_data[w_idx][r_cnt] <= mem_rdata;
            if (w_last)
                r_tag[w_idx] <= w_tag;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (r_state == S_COMPARE && w_match && !r_refilled
                && hit_cnt != 16'hFFFF)
                hit_cnt <= hit_cnt + 16'd1;
            if (r_state == S_COMPARE && !w_match && miss_cnt != 16'hFFFF)
                miss_cnt <= miss_cnt + 16'd1;
            if (r_state == S_WRITEBACK && w_xfer && w_last
                && wb_cnt != 16'hFFFF)
                wb_cnt <= wb_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed plus randomized requests against a flat-memory
// reference and a tag/valid/dirty model that predicts latency and traffic.
module tb_cache_ctrl;
    logic        clock;
    logic        reset;
    logic        read;
    logic        write;
    logic [7:0]  Address;
    logic [31:0] Write_Data;
    logic [31:0] rData;
    logic        hit;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
    logic [15:0] wb_cnt;
`endif

    cache_ctrl dut (
        .clock(clock),
        .reset(reset),
        .read(read),
        .write(write),
        .Address(Address),
        .Write_Data(Write_Data),
        .rData(rData),
        .hit(hit),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt),
        .wb_cnt(wb_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] tb_mem [64];
    logic [31:0] golden [64];
    bit          m_valid [4];
    int          m_tag [4];
    bit          m_dirty [4];
    int e_hit = 0;
    int e_miss = 0;
    int e_wb = 0;

    int n_stall;
    int n_wb;
    int n_rf;
    int rdy_mode = 0;
    bit prev_stall = 0;
    logic [7:0]  prev_addr;
    logic [31:0] prev_wdata;
    logic        prev_we;

    assign mem_rdata = tb_mem[mem_addr[7:2]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    always @(posedge clock) begin
        #2;
        if (rdy_mode == 0)
            mem_ready = 1'b1;
        else if (rdy_mode == 1)
            mem_ready = ($urandom_range(0, 2) != 0);
        else
            mem_ready = 1'b0;
    end

    // Memory side: values at negedge are what the next rising edge commits.
    always @(negedge clock) begin
        if (reset) begin
            if (prev_stall && mem_req) begin
                chk("hold_addr", mem_addr, prev_addr);
                chk("hold_we", mem_we, prev_we);
                chk("hold_wdata", mem_wdata, prev_wdata);
            end
            prev_stall = mem_req && !mem_ready;
            prev_addr  = mem_addr;
            prev_we    = mem_we;
            prev_wdata = mem_wdata;
            if (mem_req && !mem_ready)
                n_stall++;
            if (mem_req && mem_ready) begin
                if (mem_we) begin
                    chk("wb_data", mem_wdata, golden[mem_addr[7:2]]);
                    tb_mem[mem_addr[7:2]] = mem_wdata;
                    n_wb++;
                end else begin
                    n_rf++;
                end
            end
        end else begin
            prev_stall = 0;
        end
    end

    task automatic req(input bit is_rd, input bit is_wr,
                       input logic [7:0] a, input logic [31:0] d);
        int  idx;
        int  tg;
        int  w;
        int  lat;
        int  exp_lat;
        bit  hp;
        bit  dp;
        bit  got;
        idx = int'(a[4:3]);
        tg  = int'(a[7:5]);
        w   = int'(a[7:2]);
        hp  = m_valid[idx] && (m_tag[idx] == tg);
        dp  = !hp && m_valid[idx] && m_dirty[idx];
        n_stall = 0;
        n_wb = 0;
        n_rf = 0;
        read = is_rd;
        write = is_wr;
        Address = a;
        Write_Data = d;
        got = 0;
        lat = 0;
        for (int k = 1; k <= 80 && !got; k++) begin
            @(posedge clock);
            #1;
            if (hit) begin
                got = 1;
                lat = k;
            end
        end
        chk("hit_seen", 32'(got), 32'd1);
        if (got) begin
            exp_lat = 1 + (hp ? 0 : 3) + (dp ? 2 : 0) + n_stall;
            chk("latency", lat, exp_lat);
            chk("wb_words", n_wb, dp ? 2 : 0);
            chk("rf_words", n_rf, hp ? 0 : 2);
            if (!is_wr)
                chk("rData", rData, golden[w]);
        end
        read = 1'b0;
        write = 1'b0;
        if (is_wr)
            golden[w] = d;
        e_hit  += hp ? 1 : 0;
        e_miss += hp ? 0 : 1;
        e_wb   += dp ? 1 : 0;
        m_dirty[idx] = (hp ? m_dirty[idx] : 1'b0) | is_wr;
        m_valid[idx] = 1;
        m_tag[idx] = tg;
        @(posedge clock);
        #1;
        chk("hit_pulse", 32'(hit), 32'd0);
        chk("rData_idle", rData, 32'd0);
    endtask

    initial begin
        bit found;
        int op;
        logic [7:0] a;
        for (int i = 0; i < 64; i++) begin
            tb_mem[i] = $urandom;
            golden[i] = tb_mem[i];
        end
        tb_mem[8] = 32'd11;
        golden[8] = 32'd11;
        tb_mem[9] = 32'd588;
        golden[9] = 32'd588;
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
            m_tag[i] = 0;
        end
        mem_ready = 1'b1;
        reset = 1'b0;
        read = 1'b0;
        write = 1'b0;
        Address = '0;
        Write_Data = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_rData", rData, 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        req(1, 0, 8'h24, 32'd0);
        req(0, 1, 8'h24, 32'd716);
        req(1, 0, 8'hA4, 32'd0);
        chk("wb_mem20", tb_mem[8], 32'd11);
        chk("wb_mem24", tb_mem[9], 32'd716);
        req(0, 1, 8'h60, 32'd751);
        req(1, 0, 8'h60, 32'd0);
`ifdef CACHE_STATS_EN
        chk("hit_cnt_dir", 32'(hit_cnt), 32'd2);
        chk("miss_cnt_dir", 32'(miss_cnt), 32'd3);
        chk("wb_cnt_dir", 32'(wb_cnt), 32'd1);
`endif
        rdy_mode = 1;
        req(1, 0, 8'h80, 32'd0);
        req(1, 1, 8'h84, 32'd999);

        for (int i = 0; i < 40; i++) begin
            rdy_mode = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 2));
            a = 8'($urandom_range(0, 95));
            req(op == 0, op != 0, a, $urandom);
        end
        rdy_mode = 0;
`ifdef CACHE_STATS_EN
        chk("hit_cnt", 32'(hit_cnt), e_hit);
        chk("miss_cnt", 32'(miss_cnt), e_miss);
        chk("wb_cnt", 32'(wb_cnt), e_wb);
`endif

        req(1, 0, 8'h08, 32'd0);
        read = 1'b1;
        Address = 8'hE8;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clock);
            #1;
            if (mem_req && !mem_we && mem_addr == 8'hEC)
                found = 1;
        end
        chk("refill_w1_seen", 32'(found), 32'd1);
        rdy_mode = 2;
        @(posedge clock);
        #1;
        chk("stall_req", 32'(mem_req), 32'd1);
        chk("stall_addr", 32'(mem_addr), 32'hEC);
        reset = 1'b0;
        #1;
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_hit", 32'(hit), 32'd0);
        chk("abort_addr", 32'(mem_addr), 32'd0);
        read = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        rdy_mode = 0;
        for (int i = 0; i < 64; i++)
            golden[i] = tb_mem[i];
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
`ifdef CACHE_STATS_EN
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_wb_cnt", 32'(wb_cnt), 32'd0);
`endif
        @(posedge clock);
        #1;
        req(1, 0, 8'hE8, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
